// File: rtl/mul_wb_scheduler_pkg.sv
// Shared execute-stage types for the multiply/writeback scheduler.
// Slot layout and writeback source encoding.
package mul_wb_scheduler_pkg;

  localparam int MUL_DELAY_CFG = 5;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [REG_AW-1:0] rd;
  } mul_slot_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MUL = 1'b1
  } wb_src_e;

  function automatic logic slot_hit(
    input mul_slot_t         s,
    input logic [REG_AW-1:0] a
  );
    return s.valid & s.we & (a != '0) & (s.rd == a);
  endfunction

endpackage

// File: rtl/mul_slot_pipe.sv
// Occupancy shift pipe for in-flight multiplies.
// Index 0 is the slot one cycle from writeback.
module mul_slot_pipe
  import mul_wb_scheduler_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NCMP  = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en,
  input  mul_slot_t                        din,
  input  logic [NCMP-1:0][REG_AW-1:0]      cmp_rd,
  output mul_slot_t                        head,
  output logic [NCMP-1:0]                  hit,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int CW = $clog2(DEPTH + 1);

  mul_slot_t slot [DEPTH];

  // shift toward writeback; new multiplies enter at the far end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) slot[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < DEPTH - 1; i++) slot[i] <= slot[i+1];
      slot[DEPTH-1] <= din;
    end
  end

  // parallel destination compare against every pending slot
  always_comb begin
    hit = '0;
    for (int k = 0; k < NCMP; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_hit(slot[i], cmp_rd[k])) hit[k] = 1'b1;
      end
    end
  end

  // occupancy count of pending multiplies
  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CW'(slot[i].valid);
    end
  end

  assign head = slot[0];

endmodule

// File: rtl/mul_wb_scheduler.sv
// Issue-side hazard control and writeback arbitration
// between 1-cycle ALU and fixed-latency multiply results.
module mul_wb_scheduler
  import mul_wb_scheduler_pkg::*;
#(
  parameter int MUL_DELAY = MUL_DELAY_CFG
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           hold,
  input  logic                           issue_valid,
  input  logic                           issue_is_mul,
  input  logic                           issue_rd_we,
  input  logic [REG_AW-1:0]              issue_rd,
  input  logic [REG_AW-1:0]              issue_rs1,
  input  logic [REG_AW-1:0]              issue_rs2,
  input  logic                           issue_use_rs1,
  input  logic                           issue_use_rs2,
  output logic                           issue_ready,
  output logic                           stall_ex,
  output logic                           ex_advance,
  output logic                           wb_valid,
  output logic                           wb_sel_mul,
  output logic [REG_AW-1:0]              wb_rd,
  output logic [$clog2(MUL_DELAY+1)-1:0] mul_inflight
);

  localparam int DEPTH = MUL_DELAY - 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int MW    = $clog2(MUL_DELAY + 1);

  mul_slot_t               din;
  mul_slot_t               head;
  logic [2:0][REG_AW-1:0]  cmp_rd;
  logic [2:0]              hit;
  logic [CW-1:0]           count;

  logic    raw, waw, structural, hazard;
  logic    fire, alu_fire;
  wb_src_e wb_src;

  logic              nxt_valid;
  wb_src_e           nxt_src;
  logic [REG_AW-1:0] nxt_rd;

  assign cmp_rd = {issue_rd, issue_rs2, issue_rs1};

  mul_slot_pipe #(
    .DEPTH (DEPTH),
    .NCMP  (3)
  ) u_pipe (
    .clk    (clk),
    .reset  (reset),
    .en     (~hold),
    .din    (din),
    .cmp_rd (cmp_rd),
    .head   (head),
    .hit    (hit),
    .count  (count)
  );

  // hazard detection and issue handshake
  always_comb begin
    raw = (issue_use_rs1 & hit[0]) | (issue_use_rs2 & hit[1]);
    waw = issue_rd_we & hit[2];
    structural = ~issue_is_mul & issue_rd_we & head.valid & head.we;
    hazard = raw | waw | structural;
    issue_ready = ~hold & ~hazard;
    stall_ex = hold | (issue_valid & hazard);
    ex_advance = ~hold;
    fire = issue_valid & issue_ready;
    alu_fire = fire & ~issue_is_mul & issue_rd_we;
    din.valid = fire & issue_is_mul & issue_rd_we;
    din.we = issue_rd_we;
    din.rd = issue_rd;
  end

  // writeback port selection for the next cycle
  always_comb begin
    nxt_valid = 1'b0;
    nxt_src = WB_ALU;
    nxt_rd = '0;
    unique case (1'b1)
      head.valid: begin
        nxt_valid = 1'b1;
        nxt_src = WB_MUL;
        nxt_rd = head.rd;
      end
      alu_fire: begin
        nxt_valid = 1'b1;
        nxt_src = WB_ALU;
        nxt_rd = issue_rd;
      end
      default: ;
    endcase
  end

  // writeback register, frozen while hold is high
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_src <= WB_ALU;
      wb_rd <= '0;
    end else if (!hold) begin
      wb_valid <= nxt_valid;
      wb_src <= nxt_src;
      wb_rd <= nxt_rd;
    end
  end

  // both sources may never claim the port together
  always_ff @(posedge clk) begin
    if (!reset && !hold) begin
      assert (!(head.valid && alu_fire));
    end
  end

  assign wb_sel_mul = (wb_src == WB_MUL);
  assign mul_inflight = MW'(count) + MW'(wb_valid & wb_sel_mul);

endmodule

// File: tb/tb_mul_wb_scheduler.sv
// Self-checking bench for mul_wb_scheduler.
// Directed scenarios plus a randomized run against a pending-list model.
module tb_mul_wb_scheduler;

  localparam int D  = 5;
  localparam int AW = 5;
  localparam int MW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          hold;
  logic          issue_valid;
  logic          issue_is_mul;
  logic          issue_rd_we;
  logic [AW-1:0] issue_rd;
  logic [AW-1:0] issue_rs1;
  logic [AW-1:0] issue_rs2;
  logic          issue_use_rs1;
  logic          issue_use_rs2;
  logic          issue_ready;
  logic          stall_ex;
  logic          ex_advance;
  logic          wb_valid;
  logic          wb_sel_mul;
  logic [AW-1:0] wb_rd;
  logic [MW-1:0] mul_inflight;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_wb_scheduler #(
    .MUL_DELAY (D)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .hold          (hold),
    .issue_valid   (issue_valid),
    .issue_is_mul  (issue_is_mul),
    .issue_rd_we   (issue_rd_we),
    .issue_rd      (issue_rd),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_use_rs1 (issue_use_rs1),
    .issue_use_rs2 (issue_use_rs2),
    .issue_ready   (issue_ready),
    .stall_ex      (stall_ex),
    .ex_advance    (ex_advance),
    .wb_valid      (wb_valid),
    .wb_sel_mul    (wb_sel_mul),
    .wb_rd         (wb_rd),
    .mul_inflight  (mul_inflight)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hold = 1'b0;
    issue_valid = 1'b0;
    issue_is_mul = 1'b0;
    issue_rd_we = 1'b0;
    issue_rd = '0;
    issue_rs1 = '0;
    issue_rs2 = '0;
    issue_use_rs1 = 1'b0;
    issue_use_rs2 = 1'b0;
  endtask

  task automatic issue_mul(input logic [AW-1:0] rd);
    idle();
    issue_valid = 1'b1;
    issue_is_mul = 1'b1;
    issue_rd_we = 1'b1;
    issue_rd = rd;
  endtask

  task automatic issue_alu(
    input logic [AW-1:0] rd,
    input logic [AW-1:0] rs1,
    input logic [AW-1:0] rs2,
    input logic          u1,
    input logic          u2
  );
    idle();
    issue_valid = 1'b1;
    issue_rd_we = 1'b1;
    issue_rd = rd;
    issue_rs1 = rs1;
    issue_rs2 = rs2;
    issue_use_rs1 = u1;
    issue_use_rs2 = u2;
  endtask

  task automatic drain();
    idle();
    repeat (D + 2) step();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_wb_valid got %0b want 0", wb_valid);
    end
    checks++;
    if (mul_inflight !== '0) begin
      errors++;
      $display("FAIL reset_inflight got %0d want 0", mul_inflight);
    end
    checks++;
    if (wb_rd !== '0 || wb_sel_mul !== 1'b0) begin
      errors++;
      $display("FAIL reset_wb_rd got %0d/%0b want 0/0", wb_rd, wb_sel_mul);
    end
    checks++;
    if (issue_ready !== 1'b1 || ex_advance !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %0b/%0b want 1/1",
               issue_ready, ex_advance);
    end
  endtask

  task automatic test_mul_latency();
    drain();
    step();
    issue_mul(5'd3);
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL lat_ready got %0b want 1", issue_ready);
    end
    for (int c = 1; c <= 6; c++) begin
      step();
      idle();
      checks++;
      if (wb_valid !== (c == 5)) begin
        errors++;
        $display("FAIL lat_wb_valid c=%0d got %0b want %0b",
                 c, wb_valid, (c == 5));
      end
      if (c == 5) begin
        checks++;
        if (wb_sel_mul !== 1'b1 || wb_rd !== 5'd3) begin
          errors++;
          $display("FAIL lat_wb_rd got %0b/%0d want 1/3", wb_sel_mul, wb_rd);
        end
      end
      checks++;
      if (mul_inflight !== MW'(c <= 5 ? 1 : 0)) begin
        errors++;
        $display("FAIL lat_inflight c=%0d got %0d want %0d",
                 c, mul_inflight, (c <= 5 ? 1 : 0));
      end
    end
  endtask

  task automatic test_structural();
    drain();
    step();
    issue_mul(5'd3);
    for (int c = 1; c <= 3; c++) begin
      step();
      idle();
    end
    step();
    issue_alu(5'd7, 5'd1, 5'd2, 1'b1, 1'b1);
    #1;
    checks++;
    if (issue_ready !== 1'b0 || stall_ex !== 1'b1) begin
      errors++;
      $display("FAIL struct_c4 got ready=%0b stall=%0b want 0/1",
               issue_ready, stall_ex);
    end
    step();
    #1;
    checks++;
    if (issue_ready !== 1'b1 || stall_ex !== 1'b0) begin
      errors++;
      $display("FAIL struct_c5 got ready=%0b stall=%0b want 1/0",
               issue_ready, stall_ex);
    end
    checks++;
    if (wb_valid !== 1'b1 || wb_sel_mul !== 1'b1 || wb_rd !== 5'd3) begin
      errors++;
      $display("FAIL struct_mul_wb got %0b/%0b/%0d want 1/1/3",
               wb_valid, wb_sel_mul, wb_rd);
    end
    step();
    idle();
    checks++;
    if (wb_valid !== 1'b1 || wb_sel_mul !== 1'b0 || wb_rd !== 5'd7) begin
      errors++;
      $display("FAIL struct_alu_wb got %0b/%0b/%0d want 1/0/7",
               wb_valid, wb_sel_mul, wb_rd);
    end
    step();
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL struct_wb_after got %0b want 0", wb_valid);
    end
  endtask

  task automatic test_raw();
    drain();
    step();
    issue_mul(5'd5);
    for (int c = 1; c <= 5; c++) begin
      step();
      issue_alu(5'd9, 5'd5, 5'd0, 1'b1, 1'b0);
      #1;
      checks++;
      if (issue_ready !== (c == 5) || stall_ex !== (c != 5)) begin
        errors++;
        $display("FAIL raw_stall c=%0d got ready=%0b stall=%0b want %0b/%0b",
                 c, issue_ready, stall_ex, (c == 5), (c != 5));
      end
    end
    step();
    idle();
    checks++;
    if (wb_valid !== 1'b1 || wb_sel_mul !== 1'b0 || wb_rd !== 5'd9) begin
      errors++;
      $display("FAIL raw_alu_wb got %0b/%0b/%0d want 1/0/9",
               wb_valid, wb_sel_mul, wb_rd);
    end
    drain();
    step();
    issue_mul(5'd0);
    step();
    issue_alu(5'd9, 5'd0, 5'd0, 1'b1, 1'b1);
    #1;
    checks++;
    if (issue_ready !== 1'b1 || stall_ex !== 1'b0) begin
      errors++;
      $display("FAIL raw_x0 got ready=%0b stall=%0b want 1/0",
               issue_ready, stall_ex);
    end
    step();
    idle();
  endtask

  task automatic test_back_to_back();
    int exp_cnt [1:8] = '{1, 2, 3, 3, 3, 2, 1, 0};
    drain();
    for (int c = 0; c <= 8; c++) begin
      step();
      if (c <= 2) issue_mul(AW'(c + 1));
      else idle();
      if (c >= 1) begin
        checks++;
        if (mul_inflight !== MW'(exp_cnt[c])) begin
          errors++;
          $display("FAIL b2b_inflight c=%0d got %0d want %0d",
                   c, mul_inflight, exp_cnt[c]);
        end
        checks++;
        if (wb_valid !== (c >= 5 && c <= 7)) begin
          errors++;
          $display("FAIL b2b_wb_valid c=%0d got %0b", c, wb_valid);
        end
        if (c >= 5 && c <= 7) begin
          checks++;
          if (wb_rd !== AW'(c - 4) || wb_sel_mul !== 1'b1) begin
            errors++;
            $display("FAIL b2b_wb_rd c=%0d got %0d want %0d",
                     c, wb_rd, c - 4);
          end
        end
      end
      if (c <= 2) begin
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready c=%0d got %0b want 1", c, issue_ready);
        end
      end
    end
  endtask

  task automatic test_hold();
    drain();
    for (int c = 0; c <= 8; c++) begin
      step();
      if (c == 0) issue_mul(5'd6);
      else if (c == 2 || c == 3) begin
        issue_alu(5'd10, 5'd11, 5'd12, 1'b1, 1'b1);
        hold = 1'b1;
      end else idle();
      if (c >= 1) begin
        checks++;
        if (wb_valid !== (c == 7)) begin
          errors++;
          $display("FAIL hold_wb_valid c=%0d got %0b want %0b",
                   c, wb_valid, (c == 7));
        end
      end
      if (c == 7) begin
        checks++;
        if (wb_rd !== 5'd6 || wb_sel_mul !== 1'b1) begin
          errors++;
          $display("FAIL hold_wb_rd got %0d want 6", wb_rd);
        end
      end
      if (c == 2 || c == 3) begin
        #1;
        checks++;
        if (issue_ready !== 1'b0 || stall_ex !== 1'b1 ||
            ex_advance !== 1'b0) begin
          errors++;
          $display("FAIL hold_ctrl c=%0d got %0b/%0b/%0b want 0/1/0",
                   c, issue_ready, stall_ex, ex_advance);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    drain();
    step();
    issue_mul(5'd8);
    step();
    idle();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (mul_inflight !== '0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state got %0d/%0b want 0/0",
               mul_inflight, wb_valid);
    end
    issue_alu(5'd4, 5'd8, 5'd8, 1'b1, 1'b1);
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready got %0b want 1", issue_ready);
    end
    step();
    idle();
    checks++;
    if (wb_valid !== 1'b1 || wb_sel_mul !== 1'b0 || wb_rd !== 5'd4) begin
      errors++;
      $display("FAIL rstmid_alu_wb got %0b/%0b/%0d want 1/0/4",
               wb_valid, wb_sel_mul, wb_rd);
    end
    for (int c = 5; c <= 8; c++) begin
      step();
      checks++;
      if (wb_valid !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_no_wb c=%0d got %0b want 0", c, wb_valid);
      end
    end
  endtask

  task automatic test_random();
    int          prem [$];
    logic [AW-1:0] prd [$];
    int          nrem [$];
    logic [AW-1:0] nrd [$];
    logic        ev, em, haz, er, fire;
    logic [AW-1:0] erd;
    int          ecnt;
    drain();
    ev = 1'b0;
    em = 1'b0;
    erd = '0;
    for (int n = 0; n < 400; n++) begin
      step();
      ecnt = prem.size() + ((ev && em) ? 1 : 0);
      checks++;
      if (wb_valid !== ev || wb_sel_mul !== em || wb_rd !== erd) begin
        errors++;
        $display("FAIL rnd_wb n=%0d got %0b/%0b/%0d want %0b/%0b/%0d",
                 n, wb_valid, wb_sel_mul, wb_rd, ev, em, erd);
      end
      checks++;
      if (mul_inflight !== MW'(ecnt)) begin
        errors++;
        $display("FAIL rnd_inflight n=%0d got %0d want %0d",
                 n, mul_inflight, ecnt);
      end
      hold = ($urandom_range(0, 99) < 15);
      issue_valid = ($urandom_range(0, 99) < 75);
      issue_is_mul = ($urandom_range(0, 99) < 40);
      issue_rd_we = ($urandom_range(0, 99) < 85);
      issue_rd = AW'($urandom_range(0, 7));
      issue_rs1 = AW'($urandom_range(0, 7));
      issue_rs2 = AW'($urandom_range(0, 7));
      issue_use_rs1 = $urandom_range(0, 1);
      issue_use_rs2 = $urandom_range(0, 1);
      #1;
      haz = 1'b0;
      for (int k = 0; k < prem.size(); k++) begin
        if (prd[k] != 0 &&
            ((issue_use_rs1 && issue_rs1 == prd[k]) ||
             (issue_use_rs2 && issue_rs2 == prd[k]) ||
             (issue_rd_we && issue_rd == prd[k])))
          haz = 1'b1;
        if (!issue_is_mul && issue_rd_we && prem[k] == 1) haz = 1'b1;
      end
      er = !hold && !haz;
      checks++;
      if (issue_ready !== er || stall_ex !== (hold || (issue_valid && haz)) ||
          ex_advance !== !hold) begin
        errors++;
        $display("FAIL rnd_ctrl n=%0d got %0b/%0b/%0b want %0b/%0b/%0b",
                 n, issue_ready, stall_ex, ex_advance,
                 er, (hold || (issue_valid && haz)), !hold);
      end
      if (!hold) begin
        fire = issue_valid && er;
        ev = 1'b0;
        em = 1'b0;
        erd = '0;
        if (fire && !issue_is_mul && issue_rd_we) begin
          ev = 1'b1;
          erd = issue_rd;
        end
        nrem.delete();
        nrd.delete();
        for (int k = 0; k < prem.size(); k++) begin
          if (prem[k] == 1) begin
            ev = 1'b1;
            em = 1'b1;
            erd = prd[k];
          end else begin
            nrem.push_back(prem[k] - 1);
            nrd.push_back(prd[k]);
          end
        end
        if (fire && issue_is_mul && issue_rd_we) begin
          nrem.push_back(D - 1);
          nrd.push_back(issue_rd);
        end
        prem = nrem;
        prd = nrd;
      end
    end
    step();
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_mul_latency();
    test_structural();
    test_raw();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_wb_scheduler.md
Name: mul_wb_scheduler

Overview:
- Issue-side controller for the execute stage. Tracks every in-flight multiply in a MUL_DELAY-deep occupancy pipeline and arbitrates the single writeback port between 1-cycle ALU results and MUL_DELAY-cycle multiply results.
- Detects RAW/WAW hazards against pending multiply destinations and generates the stall/advance controls for the EX stage and its delay shift registers.
- Sits between decode/issue and EX; drives the enable of the EX result-delay pipelines.

Parameters:
- MUL_DELAY, 5: multiply latency in cycles, issue to writeback; legal range ≥2.
- REG_AW, 5: register-address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- hold  in  1  downstream (MEM/cache) stall; freezes the block
- issue_valid  in  1  decode presents an instruction
- issue_is_mul  in  1  instruction is a multiply
- issue_rd_we  in  1  instruction writes rd
- issue_rd  in  REG_AW  destination register
- issue_rs1, issue_rs2  in  REG_AW  source registers
- issue_use_rs1, issue_use_rs2  in  1  source actually read
- issue_ready  out  1  instruction accepted this cycle (fire = issue_valid & issue_ready)
- stall_ex  out  1  decode must hold its instruction
- ex_advance  out  1  enable for EX delay shift registers (= ~hold)
- wb_valid  out  1  writeback port active
- wb_sel_mul  out  1  1 = MUL result, 0 = ALU result
- wb_rd  out  REG_AW  writeback destination
- mul_inflight  out  $clog2(MUL_DELAY+1)  count of pending multiplies

Behaviour:
- Slot array: MUL_DELAY-1 entries {valid, rd, we}, indexed by rem = cycles to writeback (MUL_DELAY-1 down to 1), plus a wb register (rem 0).
- Each non-hold cycle, entries shift rem→rem-1; rem 1 moves into the wb register.
- A multiply fired at cycle t enters rem=MUL_DELAY-1 at t+1. wb_valid=1, wb_sel_mul=1, wb_rd=rd occur at cycle t+MUL_DELAY.
- An ALU op (any non-mul with we) fired at t produces wb_valid=1, wb_sel_mul=0 at t+1.
- Fired instructions with we=0 occupy nothing. They still shift as invalid bubbles and never raise wb_valid.
- Structural hazard: a non-mul with we, at cycle t, conflicts if the rem=1 entry is valid with we=1. Multiplies never conflict with each other (single issue, fixed latency).
- Data hazard: a used rs1/rs2 matches a valid rem≥1 entry's rd, with rd≠0 → RAW. An issue rd_we with rd≠0 matching a valid rem≥1 entry rd → WAW. The rem 0 entry is written this cycle and is not a hazard (register file writes before read).
- hazard = structural | data.
- issue_ready = ~hold & ~hazard (combinational).
- stall_ex = hold | (issue_valid & hazard).
- ex_advance = ~hold.
- hold=1: no shift, no fire; wb outputs and all state hold their values; the consumer must ignore repeated wb_valid while hold=1.
- mul_inflight = count of valid entries at rem≥1 plus the wb register when it holds a mul. Updated in the same cycle as the shift.
- Reset (synchronous, priority over hold): all slots invalid, wb_valid=0, wb_sel_mul=0, wb_rd=0, mul_inflight=0. Reset mid-multiply discards the entries with no writeback.
- wb_valid for ALU and MUL can never coincide (guaranteed by the structural check). An assertion fires if both sources request the port.

Decomposition:
- brisc_pkg additions: REG_AW; a mul_slot_t struct {valid, we, rd}; a wb_src_e enum {WB_ALU, WB_MUL}. MUL_DELAY is already shared there.
- One sub-module: mul_slot_pipe (parameterised shift of mul_slot_t with enable, synchronous reset, and a parallel rd-compare output vector). Hazard logic and arbitration stay in the top.

Test Plan:
- MUL_DELAY=5. Fire mul rd=3 at cycle 0 → wb_valid=1, wb_sel_mul=1, wb_rd=3 at cycle 5 only. mul_inflight=1 on cycles 1-5, 0 at cycle 6.
- Mul rd=3 fired at 0; ALU add rd=7 (rs 1,2) presented at cycle 4 → issue_ready=0 and stall_ex=1 at cycle 4 (structural). Fires at 5 → ALU wb rd=7 at cycle 6.
- Mul rd=5 fired at 0; ALU reading rs1=5 presented at cycle 1 → stalled cycles 1-4, fires at cycle 5. Same with rd=0 mul → no stall.
- Back-to-back muls rd=1,2,3 at cycles 0-2 → wb at 5, 6, 7 with matching rd. mul_inflight peaks at 3 on cycles 3-5.
- Mul at 0; hold=1 on cycles 2-3 → issue_ready=0, stall_ex=1, ex_advance=0 on those cycles; writeback slips to cycle 7.
- Mul at 0; reset on cycle 2 → wb_valid never asserts, mul_inflight=0 at cycle 3. An ALU op at cycle 3 fires immediately.
